// File: rtl/defpkg.sv
// Shared pipeline definitions: stall encoding, per-boundary payload widths with
// their bubble payloads, and the boundary action enum used by pipe_stage_reg.
package defpkg;

  localparam int unsigned STALL_W = 6;
  localparam logic Stop   = 1'b1;
  localparam logic NoStop = 1'b0;

  localparam logic [4:0]  NOPRegAddr   = 5'b00000;
  localparam logic [7:0]  EXE_NOP_OP   = 8'b0000_0000;
  localparam logic [2:0]  EXE_RES_NOP  = 3'b000;
  localparam logic        WriteDisable = 1'b0;
  localparam logic [31:0] ZeroWord     = 32'h0000_0000;

  // IF/ID: {pc, inst}
  localparam int unsigned IFID_DATA_W = 64;
  localparam int unsigned IFID_SIDE_W = 1;
  localparam logic [IFID_DATA_W-1:0] IFID_NOP_DATA = {ZeroWord, ZeroWord};

  // ID/EX: {aluop, alusel, reg1, reg2, wd, wreg}
  localparam int unsigned IDEX_DATA_W = 81;
  localparam int unsigned IDEX_SIDE_W = 1;
  localparam logic [IDEX_DATA_W-1:0] IDEX_NOP_DATA =
    {EXE_NOP_OP, EXE_RES_NOP, ZeroWord, ZeroWord, NOPRegAddr, WriteDisable};

  // EX/MEM: {wd, wreg, wdata, aluop}; side = {cnt, hilo_temp}
  localparam int unsigned EXMEM_DATA_W = 46;
  localparam int unsigned EXMEM_SIDE_W = 66;
  localparam logic [EXMEM_DATA_W-1:0] EXMEM_NOP_DATA =
    {NOPRegAddr, WriteDisable, ZeroWord, EXE_NOP_OP};

  // MEM/WB: {wd, wreg, wdata}
  localparam int unsigned MEMWB_DATA_W = 38;
  localparam int unsigned MEMWB_SIDE_W = 1;
  localparam logic [MEMWB_DATA_W-1:0] MEMWB_NOP_DATA = {NOPRegAddr, WriteDisable, ZeroWord};

  typedef enum logic [2:0] {
    ActReset,
    ActFlush,
    ActBubble,
    ActAdvance,
    ActHold
  } action_e;

endpackage

// File: rtl/pipe_stat_cnt.sv
// Saturating event counter with synchronous clear; one per boundary statistic.
module pipe_stat_cnt #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (inc && (cnt != {CNT_W{1'b1}})) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline boundary register with stall/flush protocol and side-channel capture.
// Statistics counters are built only when PIPE_STAT_EN is defined.
module pipe_stage_reg
  import defpkg::*;
#(
  parameter int unsigned       DATA_W   = 32,
  parameter int unsigned       SIDE_W   = 66,
  parameter int unsigned       STALL_W  = 6,
  parameter int                STAGE    = 3,
  parameter logic [DATA_W-1:0] NOP_DATA = '0,
  parameter int unsigned       CNT_W    = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STALL_W-1:0] stall,
  input  logic               flush,
  input  logic               in_valid,
  input  logic [DATA_W-1:0]  in_data,
  input  logic [SIDE_W-1:0]  in_side,
  output logic               out_valid,
  output logic [DATA_W-1:0]  out_data,
  output logic [SIDE_W-1:0]  out_side,
  input  logic               stat_clr,
  output logic [CNT_W-1:0]   stat_stall_cnt,
  output logic [CNT_W-1:0]   stat_bubble_cnt,
  output logic [CNT_W-1:0]   stat_flush_cnt
);

  if (STAGE < 0 || STAGE > int'(STALL_W) - 2) begin : gen_stage_check
    $error("pipe_stage_reg: STAGE must lie in 0..STALL_W-2");
  end

  function automatic action_e decode_action(input logic r, input logic f,
                                            input logic stop_cur, input logic stop_next);
    if (r)                  return ActReset;
    if (f)                  return ActFlush;
    if (stop_cur == NoStop) return ActAdvance;
    if (stop_next == NoStop) return ActBubble;
    return ActHold;
  endfunction

  action_e action;
  assign action = decode_action(rst, flush, stall[STAGE], stall[STAGE+1]);

  // Only the two bits around this boundary matter; the rest belong to other stages.
  logic unused_stall;
  assign unused_stall = ^stall;

  always_ff @(posedge clk) begin
    unique case (action)
      ActBubble: begin
        out_valid <= 1'b0;
        out_data  <= NOP_DATA;
        out_side  <= in_side;
      end
      ActAdvance: begin
        out_valid <= in_valid;
        out_data  <= in_valid ? in_data : NOP_DATA;
        out_side  <= '0;
      end
      ActHold: begin
        out_side  <= in_side;
      end
      default: begin
        out_valid <= 1'b0;
        out_data  <= NOP_DATA;
        out_side  <= '0;
      end
    endcase
  end

`ifdef PIPE_STAT_EN
  // Reset clears through rst; a reset cycle is never counted as a flush.
  pipe_stat_cnt #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .clr (stat_clr),
    .inc (action == ActHold),
    .cnt (stat_stall_cnt)
  );

  pipe_stat_cnt #(.CNT_W(CNT_W)) u_bubble_cnt (
    .clk (clk),
    .rst (rst),
    .clr (stat_clr),
    .inc (action == ActBubble),
    .cnt (stat_bubble_cnt)
  );

  pipe_stat_cnt #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk (clk),
    .rst (rst),
    .clr (stat_clr),
    .inc (action == ActFlush),
    .cnt (stat_flush_cnt)
  );
`else
  logic unused_stat_clr;
  assign unused_stat_clr = stat_clr;
  assign stat_stall_cnt  = '0;
  assign stat_bubble_cnt = '0;
  assign stat_flush_cnt  = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: directed scenarios followed by random stimulus,
// checked cycle by cycle against a behavioural model of the boundary.
module tb_pipe_stage_reg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned SIDE_W = 66;
  localparam int unsigned STALL_W = 6;
  localparam int STAGE = 3;
  localparam logic [31:0] NOP = 32'hA5A5_0000;
  localparam int unsigned CNT_W = 4;
  localparam int CNT_MAX = 15;

  logic               clk;
  logic               rst;
  logic [STALL_W-1:0] stall;
  logic               flush;
  logic               in_valid;
  logic [DATA_W-1:0]  in_data;
  logic [SIDE_W-1:0]  in_side;
  logic               out_valid;
  logic [DATA_W-1:0]  out_data;
  logic [SIDE_W-1:0]  out_side;
  logic               stat_clr;
  logic [CNT_W-1:0]   stat_stall_cnt;
  logic [CNT_W-1:0]   stat_bubble_cnt;
  logic [CNT_W-1:0]   stat_flush_cnt;

  pipe_stage_reg #(
    .DATA_W   (DATA_W),
    .SIDE_W   (SIDE_W),
    .STALL_W  (STALL_W),
    .STAGE    (STAGE),
    .NOP_DATA (NOP),
    .CNT_W    (CNT_W)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .flush           (flush),
    .in_valid        (in_valid),
    .in_data         (in_data),
    .in_side         (in_side),
    .out_valid       (out_valid),
    .out_data        (out_data),
    .out_side        (out_side),
    .stat_clr        (stat_clr),
    .stat_stall_cnt  (stat_stall_cnt),
    .stat_bubble_cnt (stat_bubble_cnt),
    .stat_flush_cnt  (stat_flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic              v;
    logic [DATA_W-1:0] d;
    logic [SIDE_W-1:0] s;
    int                st;
    int                bu;
    int                fl;
  } exp_t;

  exp_t sb[$];
  int n_checks = 0;
  int n_pass = 0;

  // Behavioural model state
  logic              m_v;
  logic [DATA_W-1:0] m_d;
  logic [SIDE_W-1:0] m_s;
  int                m_st, m_bu, m_fl;

  task automatic check(input string name, input logic [SIDE_W-1:0] act,
                       input logic [SIDE_W-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  function automatic int sat_inc(input int n);
    return (n >= CNT_MAX) ? CNT_MAX : n + 1;
  endfunction

  // Apply one cycle of inputs and predict what the boundary shows after the edge.
  task automatic drive(input logic r, input logic f, input logic clr,
                       input logic [STALL_W-1:0] st, input logic v,
                       input logic [DATA_W-1:0] d, input logic [SIDE_W-1:0] s);
    exp_t e;
    bit hold_ev, bub_ev, fl_ev;
    @(negedge clk);
    rst = r; flush = f; stat_clr = clr; stall = st;
    in_valid = v; in_data = d; in_side = s;
    hold_ev = 0; bub_ev = 0; fl_ev = 0;
    if (r) begin
      m_v = 0; m_d = NOP; m_s = '0;
    end else if (f) begin
      m_v = 0; m_d = NOP; m_s = '0; fl_ev = 1;
    end else if (!st[STAGE]) begin
      m_v = v; m_d = v ? d : NOP; m_s = '0;
    end else if (!st[STAGE+1]) begin
      m_v = 0; m_d = NOP; m_s = s; bub_ev = 1;
    end else begin
      m_s = s; hold_ev = 1;
    end
    if (r || clr) begin
      m_st = 0; m_bu = 0; m_fl = 0;
    end else begin
      if (hold_ev) m_st = sat_inc(m_st);
      if (bub_ev)  m_bu = sat_inc(m_bu);
      if (fl_ev)   m_fl = sat_inc(m_fl);
    end
    e.v = m_v; e.d = m_d; e.s = m_s;
`ifdef PIPE_STAT_EN
    e.st = m_st; e.bu = m_bu; e.fl = m_fl;
`else
    e.st = 0; e.bu = 0; e.fl = 0;
`endif
    sb.push_back(e);
  endtask

  // Monitor: the register presents a new output after every edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("out_valid", SIDE_W'(out_valid), SIDE_W'(e.v));
        check("out_data", SIDE_W'(out_data), SIDE_W'(e.d));
        check("out_side", out_side, e.s);
        check("stat_stall_cnt", SIDE_W'(stat_stall_cnt), SIDE_W'(e.st));
        check("stat_bubble_cnt", SIDE_W'(stat_bubble_cnt), SIDE_W'(e.bu));
        check("stat_flush_cnt", SIDE_W'(stat_flush_cnt), SIDE_W'(e.fl));
      end
    end
  end

  function automatic logic [SIDE_W-1:0] rand_side();
    logic [95:0] r;
    r = {$urandom(), $urandom(), $urandom()};
    return r[SIDE_W-1:0];
  endfunction

  initial begin
    logic [SIDE_W-1:0] acc;
    logic [STALL_W-1:0] st;
    rst = 1'b0; flush = 1'b0; stat_clr = 1'b0; stall = '0;
    in_valid = 1'b0; in_data = '0; in_side = '0;
    m_v = 0; m_d = NOP; m_s = '0; m_st = 0; m_bu = 0; m_fl = 0;

    // Reset with live-looking inputs
    repeat (2) drive(1, 0, 0, '0, 1, 32'hDEADBEEF, rand_side());

    // Advance, then invalid input becomes a bubble payload
    drive(0, 0, 0, '0, 1, 32'h1111_1111, rand_side());
    drive(0, 0, 0, '0, 0, 32'h2222_2222, rand_side());

    // Bubble then hold, side-channel accumulating across the stall
    drive(0, 0, 0, '0, 1, 32'h3333_3333, '0);
    acc = 66'h2_0000_0001_0000_0002;
    drive(0, 0, 0, 6'b001111, 1, 32'h3434_3434, acc);
    for (int i = 0; i < 3; i++) begin
      acc = acc + 66'h1_0000_0001;
      drive(0, 0, 0, 6'b011111, 1, 32'h3535_3535, acc);
    end
    drive(0, 0, 0, '0, 0, 32'h3636_3636, acc);

    // Flush overrides a full stall while a valid instruction is held
    drive(0, 0, 0, '0, 1, 32'h4444_4444, '0);
    drive(0, 0, 0, 6'b111111, 1, 32'h4545_4545, rand_side());
    drive(0, 1, 0, 6'b111111, 1, 32'h4646_4646, rand_side());

    // Reset mid-stall discards held instruction and side-channel
    drive(0, 0, 0, '0, 1, 32'h4747_4747, '0);
    drive(0, 0, 0, 6'b011000, 1, 32'h4848_4848, rand_side());
    drive(1, 0, 0, 6'b111111, 1, 32'h4949_4949, rand_side());

    // Saturation of the hold counter, then clear during a hold cycle
    drive(0, 0, 0, '0, 1, 32'h5555_5555, '0);
    for (int i = 0; i < 20; i++) drive(0, 0, 0, 6'b011000, 0, 32'h0, rand_side());
    drive(0, 0, 1, 6'b011000, 0, 32'h0, rand_side());
    drive(0, 0, 0, 6'b011000, 0, 32'h0, rand_side());

    // Random phase
    for (int i = 0; i < 500; i++) begin
      st = STALL_W'($urandom());
      drive(($urandom_range(0, 63) == 0), ($urandom_range(0, 15) == 0),
            ($urandom_range(0, 31) == 0), st, 1'($urandom()), $urandom(), rand_side());
    end

    @(posedge clk);
    #2;
    check("scoreboard_drained", SIDE_W'(sb.size()), '0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
